// File: rtl/mem_req_arbiter.sv
// Two-port round-robin arbiter in front of the single cache-side memory-controller port.
// One transaction in flight at a time; reads are guarded by a watchdog timeout.
module mem_req_arbiter #(
    parameter int APPDATA_WIDTH    = 128,
    parameter int INPUT_ADDR_WIDTH = 31,
    parameter int RD_TIMEOUT       = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init_done,
    input  logic                          req0_wr,
    input  logic                          req0_rd,
    input  logic [INPUT_ADDR_WIDTH-1:0]   req0_addr,
    input  logic [2*APPDATA_WIDTH-1:0]    req0_wdata,
    output logic                          ack0,
    output logic                          err0,
    output logic [2*APPDATA_WIDTH-1:0]    rdata0,
    input  logic                          req1_wr,
    input  logic                          req1_rd,
    input  logic [INPUT_ADDR_WIDTH-1:0]   req1_addr,
    input  logic [2*APPDATA_WIDTH-1:0]    req1_wdata,
    output logic                          ack1,
    output logic                          err1,
    output logic [2*APPDATA_WIDTH-1:0]    rdata1,
    output logic                          data_wren,
    output logic                          data_rden,
    output logic [INPUT_ADDR_WIDTH-1:0]   data_addr,
    output logic [2*APPDATA_WIDTH-1:0]    data_wr,
    input  logic [2*APPDATA_WIDTH-1:0]    data_rd,
    input  logic                          mc_wr_rdy,
    input  logic                          mc_rd_rdy,
    input  logic                          mc_rd_valid,
    output logic                          busy
);

    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t             state, state_nxt;
    logic               last_grant;
    logic               grant_port;
    logic               op_wr;
    logic               timed_out;
    logic [CNT_W-1:0]   rd_cnt;
    logic               req0_any, req1_any;
    logic               grant, grant_sel;

    assign req0_any  = req0_wr | req0_rd;
    assign req1_any  = req1_wr | req1_rd;
    assign grant     = (state == IDLE) && init_done && (req0_any || req1_any);
    // On a tie the port that did not win last time gets the slot.
    assign grant_sel = (req0_any && req1_any) ? ~last_grant : req1_any;

    always_comb begin
        state_nxt = state;
        data_wren = 1'b0;
        data_rden = 1'b0;
        case (state)
            IDLE: begin
                if (grant) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (op_wr) begin
                    if (mc_wr_rdy) begin
                        data_wren = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (mc_rd_rdy) begin
                    data_rden = 1'b1;
                    state_nxt = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mc_rd_valid || (rd_cnt == CNT_LAST)) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_port <= 1'b0;
            op_wr      <= 1'b0;
            timed_out  <= 1'b0;
            rd_cnt     <= '0;
            data_addr  <= '0;
            data_wr    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                grant_port <= grant_sel;
                last_grant <= grant_sel;
                // Write beats read when a port raises both.
                op_wr      <= grant_sel ? req1_wr : req0_wr;
                data_addr  <= grant_sel ? req1_addr : req0_addr;
                data_wr    <= grant_sel ? req1_wdata : req0_wdata;
                timed_out  <= 1'b0;
            end
            if (data_rden) rd_cnt <= '0;
            if (state == WAIT_RD) begin
                if (mc_rd_valid) begin
                    if (grant_port) rdata1 <= data_rd;
                    else            rdata0 <= data_rd;
                end else if (rd_cnt == CNT_LAST) begin
                    timed_out <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign ack0 = (state == DONE) && !grant_port;
    assign ack1 = (state == DONE) && grant_port;
    assign err0 = ack0 && timed_out;
    assign err1 = ack1 && timed_out;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: two requesters and a memory-controller model
// driven from $urandom, checked every cycle against a transaction-level reference model.
module tb_mem_req_arbiter;

    localparam int APPW = 16;
    localparam int AW   = 16;
    localparam int LW   = 2 * APPW;
    localparam int T    = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            init_done;
    logic [1:0]      rq_wr, rq_rd;
    logic [AW-1:0]   rq_addr [2];
    logic [LW-1:0]   rq_wdata [2];
    logic            ack0, ack1, err0, err1;
    logic [LW-1:0]   rdata0, rdata1;
    logic            data_wren, data_rden, busy;
    logic [AW-1:0]   data_addr;
    logic [LW-1:0]   data_wr, data_rd;
    logic            mc_wr_rdy, mc_rd_rdy, mc_rd_valid;

    mem_req_arbiter #(
        .APPDATA_WIDTH(APPW), .INPUT_ADDR_WIDTH(AW), .RD_TIMEOUT(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .req0_wr(rq_wr[0]), .req0_rd(rq_rd[0]), .req0_addr(rq_addr[0]), .req0_wdata(rq_wdata[0]),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1_wr(rq_wr[1]), .req1_rd(rq_rd[1]), .req1_addr(rq_addr[1]), .req1_wdata(rq_wdata[1]),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .data_wren(data_wren), .data_rden(data_rden), .data_addr(data_addr),
        .data_wr(data_wr), .data_rd(data_rd),
        .mc_wr_rdy(mc_wr_rdy), .mc_rd_rdy(mc_rd_rdy), .mc_rd_valid(mc_rd_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: one outstanding transaction, described by its key cycle numbers.
    bit            m_act, m_issued, m_wr, m_err;
    int            m_port, m_last, m_s, m_lat, m_ack;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_rline;
    logic [LW-1:0] m_rdata [2];
    bit            rel_pending, init_hold, force_valid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_issued = 0; m_wr = 0; m_err = 0;
        m_port = 0; m_last = 1; m_s = 0; m_lat = 0; m_ack = -1;
        m_addr = '0; m_wdata = '0; m_rline = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    task automatic drive();
        int k;
        bit in_wait;
        if (rel_pending) begin
            rst_n = 1'b1;
            rel_pending = 0;
        end
        for (int p = 0; p < 2; p++) begin
            if (m_act && m_issued && cyc == m_ack && m_port == p) begin
                if (m_wr) rq_wr[p] = 1'b0;
                else      rq_rd[p] = 1'b0;
            end else if (!rq_wr[p] && !rq_rd[p]) begin
                if ($urandom_range(0, 2) == 0) begin
                    k = $urandom_range(0, 2);
                    rq_wr[p]    = (k != 1);
                    rq_rd[p]    = (k != 0);
                    rq_addr[p]  = AW'($urandom);
                    rq_wdata[p] = $urandom;
                end
            end else if (m_act && m_port == p && $urandom_range(0, 1) == 0) begin
                rq_addr[p]  = AW'($urandom);
                rq_wdata[p] = $urandom;
            end
        end
        if (init_hold) init_done = 1'b0;
        else init_done = init_done ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0);
        mc_wr_rdy = ($urandom_range(0, 3) != 0);
        mc_rd_rdy = ($urandom_range(0, 3) != 0);
        in_wait = m_act && m_issued && !m_wr && cyc > m_s && cyc < m_ack;
        if (in_wait) begin
            mc_rd_valid = !m_err && (cyc == m_s + m_lat);
            data_rd     = mc_rd_valid ? m_rline : LW'($urandom);
        end else begin
            mc_rd_valid = force_valid || ($urandom_range(0, 5) == 0);
            data_rd     = $urandom;
        end
        force_valid = 0;
    endtask

    task automatic check();
        bit done_c;
        done_c = m_act && m_issued && cyc == m_ack;
        chk("busy",      64'(busy),      64'(m_act));
        chk("data_wren", 64'(data_wren), 64'(m_act && !m_issued && m_wr && mc_wr_rdy));
        chk("data_rden", 64'(data_rden), 64'(m_act && !m_issued && !m_wr && mc_rd_rdy));
        chk("ack0",      64'(ack0),      64'(done_c && m_port == 0));
        chk("ack1",      64'(ack1),      64'(done_c && m_port == 1));
        chk("err0",      64'(err0),      64'(done_c && m_port == 0 && m_err));
        chk("err1",      64'(err1),      64'(done_c && m_port == 1 && m_err));
        chk("data_addr", 64'(data_addr), 64'(m_addr));
        chk("data_wr",   64'(data_wr),   64'(m_wdata));
        chk("rdata0",    64'(rdata0),    64'(m_rdata[0]));
        chk("rdata1",    64'(rdata1),    64'(m_rdata[1]));
    endtask

    task automatic update();
        bit r0, r1;
        int w;
        if (!m_act) begin
            r0 = rq_wr[0] | rq_rd[0];
            r1 = rq_wr[1] | rq_rd[1];
            if (init_done && (r0 || r1)) begin
                w = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
                m_last = w; m_port = w;
                m_act = 1; m_issued = 0; m_err = 0; m_ack = -1;
                m_wr = rq_wr[w];
                m_addr = rq_addr[w];
                m_wdata = rq_wdata[w];
            end
        end else if (!m_issued) begin
            if (m_wr ? mc_wr_rdy : mc_rd_rdy) begin
                m_issued = 1;
                m_s = cyc;
                if (m_wr) begin
                    m_err = 0;
                    m_ack = cyc + 1;
                end else begin
                    m_lat   = $urandom_range(1, T + 4);
                    m_err   = (m_lat > T);
                    m_ack   = m_err ? cyc + T + 1 : cyc + m_lat + 1;
                    m_rline = $urandom;
                end
            end
        end else begin
            if (cyc == m_ack - 1 && !m_wr && !m_err) m_rdata[m_port] = m_rline;
            if (cyc == m_ack) m_act = 0;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        check();
        update();
    endtask

    task automatic mid_reset();
        int guard = 0;
        while (!(m_act && m_issued && !m_wr && cyc > m_s && cyc < m_ack) && guard < 3000) begin
            step();
            guard++;
        end
        chk("reach_wait_rd", 64'(guard < 3000), 64'(1));
        @(negedge clk);
        rst_n = 1'b0;
        mc_rd_valid = 1'b1;
        data_rd = $urandom;
        model_reset();
        #1;
        check();
        rel_pending = 1;
        force_valid = 1;
    endtask

    initial begin
        rst_n = 1'b0;
        init_done = 1'b0;
        rq_wr = '0; rq_rd = '0;
        rq_addr[0] = '0; rq_addr[1] = '0;
        rq_wdata[0] = '0; rq_wdata[1] = '0;
        mc_wr_rdy = 1'b0; mc_rd_rdy = 1'b0; mc_rd_valid = 1'b0;
        data_rd = '0;
        rel_pending = 0; init_hold = 0; force_valid = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check();

        // Both ports asking for reads while init_done is held low: nothing may be granted.
        rq_rd = 2'b11;
        rq_addr[0] = 16'h0100; rq_addr[1] = 16'h0200;
        rq_wdata[0] = 32'hA5A5_A5A5; rq_wdata[1] = 32'h5A5A_5A5A;
        rel_pending = 1;
        init_hold = 1;
        repeat (6) step();
        init_hold = 0;

        repeat (1500) step();
        mid_reset();
        repeat (1500) step();
        mid_reset();
        repeat (500) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Two-port round-robin arbiter that shares the single cache-side memory-controller port (data_wren/data_rden/data_wr/data_rd/data_addr with mc_wr_rdy/mc_rd_rdy/mc_rd_valid) between two requesters, e.g. instruction and data cache. It sits between the caches and the DDR2 memory interface block. It allows exactly one transaction in flight, routes read data back to the granted port, and guards reads with a watchdog timeout.

## Interface
- APPDATA_WIDTH, 128, MIG user data width; the line width is 2*APPDATA_WIDTH (256).
- INPUT_ADDR_WIDTH, 31, byte/line address width passed through to data_addr.
- RD_TIMEOUT, 1024, cycles to wait in WAIT_RD before aborting; must be ≥2. The counter is clog2(RD_TIMEOUT) bits.
- clk  in  1  single clock domain for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- init_done  in  1  phy_init_done from the memory interface; no grant is issued while it is low.
- req0_wr, req0_rd  in  1 each  port 0 write/read request. Level signals, held until ack0.
- req0_addr  in  INPUT_ADDR_WIDTH  port 0 address.
- req0_wdata  in  2*APPDATA_WIDTH  port 0 write line.
- ack0  out  1  one-cycle completion pulse for port 0.
- err0  out  1  pulses with ack0 when a read timed out.
- rdata0  out  2*APPDATA_WIDTH  last read line for port 0. Held until the next port-0 read completes.
- req1_wr, req1_rd, req1_addr, req1_wdata, ack1, err1, rdata1: same as the port 0 signals, for port 1.
- data_wren, data_rden  out  1 each  one-cycle strobes to the memory interface.
- data_addr  out  INPUT_ADDR_WIDTH  latched address of the granted request.
- data_wr  out  2*APPDATA_WIDTH  latched write line.
- data_rd  in  2*APPDATA_WIDTH  read line; valid only while mc_rd_valid=1.
- mc_wr_rdy, mc_rd_rdy, mc_rd_valid  in  1 each  memory interface status.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - Requires init_done=1 and at least one port requesting (wr|rd).
  - Selects the port, latches addr, wdata and op into data_addr, data_wr and the op/port registers, then moves to ISSUE.
- Arbitration:
  - If only one port is requesting, that port wins.
  - If both are requesting, the port ≠ last_grant wins. last_grant updates on every grant.
- Within a port, if wr and rd are both high, the write wins. The read remains pending for a later grant.
- ISSUE, write: data_wren = (op==WR && mc_wr_rdy), generated combinationally from state. On that cycle the FSM moves to DONE. While mc_wr_rdy=0 the FSM stays in ISSUE with no strobe.
- ISSUE, read: data_rden = (op==RD && mc_rd_rdy). On that cycle the FSM moves to WAIT_RD and clears the timeout counter.
- WAIT_RD:
  - On mc_rd_valid, data_rd is captured into rdata of the granted port and the FSM moves to DONE.
  - Otherwise the counter increments. When it reaches RD_TIMEOUT-1 the FSM moves to DONE with the error flag set, and rdata is left unchanged.
- DONE: ack of the granted port =1 for this cycle only, err =1 if a timeout occurred, then the FSM returns to IDLE. The requester drops its request at the clock edge that ends DONE.
- mc_rd_valid outside WAIT_RD is ignored.
- Latched address and data are not affected by requester changes after the grant.

## Timing
- Reset (async, rst_n=0):
  - State = IDLE and last_grant = 1, so port 0 wins the first tie.
  - Outputs: ack*, err*, data_wren, data_rden and busy = 0; data_addr, data_wr, rdata0 and rdata1 = 0; timeout counter = 0.
- Reset mid-transaction: strobes drop immediately and any in-flight read response is discarded.
- Write latency, with mc_wr_rdy=1: request sampled in IDLE at cycle N, data_wren at N+1, ack at N+2.
- Read latency: data_rden at N+1. If mc_rd_valid arrives at cycle M (M ≥ N+2), ack and the new rdata appear at M+1.
- Back-to-back throughput: the next grant is sampled in the IDLE cycle after DONE, so a write takes at least 3 cycles per transaction.
- The ack pulse is exactly 1 cycle. Neither strobe is ever asserted for more than 1 cycle per transaction.
- Timeout: the abort ack arrives exactly RD_TIMEOUT cycles after the cycle following data_rden.
- init_done falling mid-transaction does not abort the transaction. It only blocks new grants.

## Test plan
- Single write, port 0: req0_wr=1, addr=0x100, wdata=0xA5..A5, mc_wr_rdy=1 → data_wren at N+1 with data_addr=0x100, ack0 at N+2; ack1 stays 0.
- Write stall: mc_wr_rdy=0 for 5 cycles, then 1 → busy held, no strobe for 5 cycles, a single data_wren, then ack0 one cycle later.
- Tie and round-robin: both ports issue reads continuously, and the model returns mc_rd_valid 3 cycles after data_rden → grant order 0,1,0,1; rdata0 and rdata1 each hold their own returned lines.
- Write-over-read: req1_wr=1 and req1_rd=1 in the same cycle → the write is issued first, then the read on the following grant.
- Read timeout: RD_TIMEOUT=8, mc_rd_valid never asserts → ack0=1 and err0=1 exactly 8 cycles into WAIT_RD, rdata0 unchanged; the next request is granted normally.
- Reset and init: rst_n low during WAIT_RD → all outputs 0 at once, and a late mc_rd_valid is ignored. With init_done=0 and requests asserted, there is no grant until init_done rises.
